// File: rtl/ram_dp_if.sv
// Bus bundle for ram_dp: one write port with lane enables and one read port
// with a registered, valid-qualified response.
interface ram_dp_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int LANE  = 8
);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NLANE = WIDTH / LANE;

  // Handshake: WE/RE are taken at a posedge only while BUSY is low (BUSY is
  // the inverse of ready, no other backpressure). RVALID marks RDATA/COLL as
  // fresh for exactly the one cycle after the accepting edge.
  logic             WE;
  logic [AW-1:0]    WADDR;
  logic [WIDTH-1:0] WDATA;
  logic [NLANE-1:0] WBE;
  logic             RE;
  logic [AW-1:0]    RADDR;
  logic [WIDTH-1:0] RDATA;
  logic             RVALID;
  logic             COLL;
  logic             BUSY;

  modport master (
    output WE, WADDR, WDATA, WBE, RE, RADDR,
    input  RDATA, RVALID, COLL, BUSY
  );

  modport slave (
    input  WE, WADDR, WDATA, WBE, RE, RADDR,
    output RDATA, RVALID, COLL, BUSY
  );
endinterface

// File: rtl/ram_dp.sv
// Simple-dual-port RAM with lane enables, registered read, and a clear
// sequencer that zeroes the array after reset and on CLR.
module ram_dp #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 32,
  parameter int LANE     = 8,
  parameter int RDW_MODE = 0
) (
  input  logic     CLK,
  input  logic     RST_,
  input  logic     CLR,
  ram_dp_if.slave  bus,
  output logic     DBG_STATE
);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NLANE = WIDTH / LANE;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t           state;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q;
  logic             coll_q;

  logic             acc;
  logic             wr_in;
  logic             rd_in;
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] rd_old;
  logic [WIDTH-1:0] wr_word;
  logic [WIDTH-1:0] rd_word;
  logic             do_wr;
  logic             coll_c;

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_w,
                                             input logic [WIDTH-1:0] new_w,
                                             input logic [NLANE-1:0] be);
    logic [WIDTH-1:0] r;
    r = old_w;
    for (int i = 0; i < NLANE; i++) begin
      if (be[i]) r[i*LANE +: LANE] = new_w[i*LANE +: LANE];
    end
    return r;
  endfunction

  // Accesses only count in IDLE and never on the edge that accepts CLR.
  assign acc     = (state == S_IDLE) && !CLR;
  assign wr_in   = int'(bus.WADDR) < DEPTH;
  assign rd_in   = int'(bus.RADDR) < DEPTH;
  assign wr_old  = wr_in ? mem[bus.WADDR] : '0;
  assign rd_old  = rd_in ? mem[bus.RADDR] : '0;
  assign wr_word = merge(wr_old, bus.WDATA, bus.WBE);
  assign do_wr   = acc && bus.WE && wr_in && (|bus.WBE);
  assign coll_c  = acc && bus.RE && bus.WE && rd_in && wr_in &&
                   (bus.RADDR == bus.WADDR) && (|bus.WBE);
  assign rd_word = ((RDW_MODE == 1) && coll_c) ? wr_word : rd_old;

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      state    <= S_CLEAR;
      cnt      <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          rvalid_q <= 1'b0;
          coll_q   <= 1'b0;
          if (cnt == LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (CLR) begin
            state    <= S_CLEAR;
            cnt      <= '0;
            rvalid_q <= 1'b0;
            coll_q   <= 1'b0;
          end else begin
            rvalid_q <= bus.RE;
            coll_q   <= coll_c;
            if (bus.RE) rdata_q <= rd_word;
          end
        end
      endcase
    end
  end

  // The array has no reset; the sweep owns the write port while clearing.
  always_ff @(posedge CLK) begin
    if (state == S_CLEAR) mem[cnt] <= '0;
    else if (do_wr)       mem[bus.WADDR] <= wr_word;
  end

  assign bus.RDATA  = rdata_q;
  assign bus.RVALID = rvalid_q;
  assign bus.COLL   = coll_q;
  assign bus.BUSY   = (state == S_CLEAR);
  assign DBG_STATE  = state;
endmodule

// File: doc/ram_dp.md
# ram_dp

Parametrised simple-dual-port synchronous RAM: one write port with per-lane byte enables and one read port with a registered output and valid strobe. It replaces the single-port bidirectional-bus RAM in the register-file/memory layer wherever simultaneous read and write are needed. A built-in clear sequencer zeroes the whole array after every reset and on request. While clearing, the RAM reports BUSY and ignores accesses.

## Interface
- WIDTH, 16: data word width in bits; must be a multiple of LANE.
- DEPTH, 32: number of words; need not be a power of two.
- LANE, 8: bits per byte-enable lane; NLANE = WIDTH/LANE.
- RDW_MODE, 0: read-during-write on the same address. 0 = return old word; 1 = return merged new word.
- AW (derived, not overridable): $clog2(DEPTH).

Ports:
- CLK  in  1  single clock; all state updates on posedge.
- RST_  in  1  asynchronous, active-low reset.
- CLR  in  1  request a full clear sweep; sampled each posedge.
- WE  in  1  write enable.
- WADDR  in  AW  write address.
- WDATA  in  WIDTH  write data.
- WBE  in  NLANE  lane enables; bit i covers WDATA[i*LANE +: LANE].
- RE  in  1  read enable.
- RADDR  in  AW  read address.
- RDATA  out  WIDTH  registered read data.
- RVALID  out  1  one-cycle pulse: RDATA updated this cycle.
- COLL  out  1  one-cycle pulse with RVALID: the read hit the address written in the same cycle.
- BUSY  out  1  clear sweep in progress; accesses ignored.

## Operation
- Reset values while RST_ is low: RDATA = 0, RVALID = 0, COLL = 0, BUSY = 1, state = CLEAR, clear counter = 0. The array is not reset directly; the sweep clears it.
- States:
  - CLEAR: each posedge writes 0 to MEM[cnt] and increments cnt. When the edge writes cnt == DEPTH-1, go to IDLE.
  - IDLE: normal accesses. CLR = 1 at a posedge goes to CLEAR with cnt = 0, and that edge performs no write or read.
- BUSY = 1 exactly when state is CLEAR.
- While BUSY, WE, RE and CLR are ignored: no write, RVALID = 0, COLL = 0. A CLR during CLEAR does not restart the sweep.
- Write (IDLE, WE = 1, CLR = 0): for each lane i with WBE[i] = 1, MEM[WADDR] lane i takes WDATA lane i. Other lanes are unchanged. WBE = 0 writes nothing.
- Read (IDLE, RE = 1, CLR = 0): RDATA is loaded with MEM[RADDR] and RVALID = 1 for one cycle. When RE = 0, RDATA holds its last value and RVALID = 0.
- Collision (RE and WE both set, RADDR == WADDR, WBE != 0): COLL = 1 alongside RVALID.
  - RDW_MODE 0: RDATA is the pre-write word.
  - RDW_MODE 1: RDATA is the old word with the enabled lanes replaced by WDATA.
- Out-of-range address (>= DEPTH):
  - Writes are dropped.
  - Reads return 0 with RVALID = 1 and COLL = 0.
- Reset asserted mid-sweep or mid-access: outputs are forced immediately to their reset values. The sweep restarts from address 0 after release.

## Timing
- Read latency is 1 cycle. RE sampled at edge k gives RDATA/RVALID valid after edge k until edge k+1.
- Write takes effect at the sampling edge. A read of the same address at edge k+1 returns the new data.
- Sweep after reset release: edges 1..DEPTH clear addresses 0..DEPTH-1. BUSY falls after edge DEPTH. The first accepted access is at edge DEPTH+1.
- CLR accepted at edge n: BUSY rises after edge n. Edges n+1..n+DEPTH clear the array. BUSY falls after edge n+DEPTH.
- Read and write ports are independent. Both may be active every cycle in IDLE, giving full throughput.

## Test plan
- Reset release, defaults: BUSY = 1 for exactly 32 cycles, then 0. Read all 32 addresses: each returns 0x0000 one cycle after RE, with RVALID pulsing.
- Byte-enable write:
  - Write 0xA5C3 to addr 5 with WBE = 2'b11, then 0x1200 with WBE = 2'b10. The next read of addr 5 returns 0x12C3.
  - A write with WBE = 2'b00 leaves the word unchanged.
- Collision, addr 7 = 0x1111; same-cycle write of 0x2222 (WBE = 11) and read of addr 7:
  - RDW_MODE 0: RDATA = 0x1111 and COLL = 1; a following read returns 0x2222.
  - RDW_MODE 1: RDATA = 0x2222 and COLL = 1.
- CLR mid-traffic: fill addr 0..31 with nonzero data, then assert CLR. BUSY goes high for 32 cycles; WE/RE during that time are ignored (RVALID stays 0). All reads afterwards return 0.
- Reset mid-sweep: pull RST_ low at sweep cycle 10. RDATA, RVALID and COLL go to 0 immediately and BUSY stays 1. After release the full 32-cycle sweep repeats.
- DEPTH = 20, WIDTH = 32, LANE = 8:
  - Write to addr 25 is dropped; a read of addr 25 returns 0 with RVALID = 1.
  - Addr 19 writes and reads back correctly.
  - The sweep lasts 20 cycles.
